cond_flag_stage: RTL and testbench
==================================

Name: cond_flag_stage

Overview:
- Single-cycle stage directly downstream of the ALU.
- Holds the architectural NZCV flag register and evaluates the ARM condition field of each instruction against it.
- Commits flag updates; registers the ALU result for register-file writeback.
- Feeds the committed carry back to the ALU carry input for ADC/SBC/RSC.

Parameters:
- CNT_W, 8, width of the saturating condition-failed instruction counter.

Ports:
- clk  in  1  stage clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  ALU output holds a real instruction this cycle
- stall  in  1  freeze the stage; all registers hold
- cond  in  4  ARM condition field: 0 EQ, 1 NE, 2 CS, 3 CC, 4 MI, 5 PL, 6 VS, 7 VC, 8 HI, 9 LS, A GE, B LT, C GT, D LE, E AL, F NV
- opcode  in  4  ALU opcode, same encoding as ALU: 0 AND … 8 TST, 9 TEQ, A CMP, B CMN, … F MVN
- s_bit  in  1  instruction requests flag update
- rd  in  4  destination register index
- alu_out  in  32  ALU result
- alu_flags  in  4  ALU flags: [3] N, [2] Z, [1] C, [0] V
- nzcv  out  4  committed flags, same bit order
- carry_to_alu  out  1  equals nzcv[1]
- wb_valid  out  1  write wb_data to wb_rd this cycle
- wb_rd  out  4  registered destination index
- wb_data  out  32  registered result
- skip_count  out  CNT_W  saturating count of condition-failed valid instructions

Behaviour:
- Reset (async, immediate): nzcv=0, wb_valid=0, wb_rd=0, wb_data=0, skip_count=0.
- Condition pass (combinational, from the current nzcv register, not from alu_flags):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; NV 0
- exec = in_valid & pass & !stall.
- is_cmp = opcode in {8,9,A,B}. is_logic = opcode in {0,1,8,9,C,D,E,F}.
- Flag write (on clock edge):
  - Condition: exec & (s_bit | is_cmp). Compare ops always update flags, even when s_bit=0.
  - is_logic: N, Z, C come from alu_flags; V is preserved.
  - Otherwise: all four bits come from alu_flags.
- Writeback register, when !stall:
  - wb_valid <= exec & !is_cmp.
  - wb_rd <= rd and wb_data <= alu_out when exec & !is_cmp; otherwise both hold their previous values.
- Stall: nzcv, wb_valid, wb_rd, wb_data and skip_count all hold. wb_valid is not cleared, because downstream is frozen by the same stall.
- Latency: one cycle from ALU output to wb_*; flags visible on nzcv the cycle after commit.
  - Back-to-back dependent instructions (ADDS then ADC, CMP then BEQ-style cond) see the updated flags with no bubble.
- skip_count increments on in_valid & !pass & !stall and saturates at all-ones.
- in_valid=0 produces no flag change, wb_valid=0 and no count change.
- cond=NV is never executed and counts as skipped.
- A reset asserted mid-stream clears everything immediately; the first instruction after release sees nzcv=0 (EQ fails, NE passes).

Test Plan:
1. Reset, then ADD with cond=E, s_bit=0, rd=3, alu_out=5, alu_flags=4'b1111 -> next cycle wb_valid=1, wb_rd=3, wb_data=5; nzcv stays 0000.
2. CMP (opcode A) with s_bit=0, alu_flags=4'b0100 -> wb_valid=0, nzcv=0100. Next instruction cond=0 (EQ) writes back; following instruction with cond=1 (NE) does not write back and skip_count=1.
3. With nzcv=0001, issue TST (opcode 8), alu_flags=4'b1010 -> nzcv=1011 (V preserved). Then issue SUBS, alu_flags=4'b0010 -> nzcv=0010 and carry_to_alu=1.
4. Signed conditions: preset nzcv=1000 -> LT (B) passes, GE (A) fails. Preset nzcv=1001 -> GE passes, GT (C) passes, LE (D) fails.
5. Stall: a valid ADDS with alu_flags=1000 and stall=1 for 3 cycles -> nzcv, wb_* and skip_count unchanged throughout; wb_valid holds its prior value. On release with the instruction still present -> committed exactly once.
6. Issue 300 NV instructions -> skip_count saturates at 255. Then assert reset mid-cycle -> all outputs are 0 before the next clock edge.

Source files
------------

// File: rtl/cond_flag_stage.sv
// Flag/condition stage behind the ALU: holds NZCV, evaluates the ARM condition
// field, commits flag updates and registers the ALU result for writeback.
module cond_flag_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic [3:0]       cond,
  input  logic [3:0]       opcode,
  input  logic             s_bit,
  input  logic [3:0]       rd,
  input  logic [31:0]      alu_out,
  input  logic [3:0]       alu_flags,
  output logic [3:0]       nzcv,
  output logic             carry_to_alu,
  output logic             wb_valid,
  output logic [3:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic [CNT_W-1:0] skip_count
);

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_e;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } op_e;

  logic flag_n, flag_z, flag_c, flag_v;
  logic pass;
  logic exec;
  logic is_cmp;
  logic is_logic;
  logic flag_wr;
  logic wb_wr;

  assign flag_n = nzcv[3];
  assign flag_z = nzcv[2];
  assign flag_c = nzcv[1];
  assign flag_v = nzcv[0];

  // Condition is judged against the committed flags, never the in-flight alu_flags.
  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      CC_EQ: pass = flag_z;
      CC_NE: pass = !flag_z;
      CC_CS: pass = flag_c;
      CC_CC: pass = !flag_c;
      CC_MI: pass = flag_n;
      CC_PL: pass = !flag_n;
      CC_VS: pass = flag_v;
      CC_VC: pass = !flag_v;
      CC_HI: pass = flag_c && !flag_z;
      CC_LS: pass = !flag_c || flag_z;
      CC_GE: pass = (flag_n == flag_v);
      CC_LT: pass = (flag_n != flag_v);
      CC_GT: pass = !flag_z && (flag_n == flag_v);
      CC_LE: pass = flag_z || (flag_n != flag_v);
      CC_AL: pass = 1'b1;
      CC_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

  always_comb begin
    is_cmp   = 1'b0;
    is_logic = 1'b0;
    case (op_e'(opcode))
      OP_TST, OP_TEQ: begin
        is_cmp   = 1'b1;
        is_logic = 1'b1;
      end
      OP_CMP, OP_CMN: is_cmp = 1'b1;
      OP_AND, OP_EOR, OP_ORR, OP_MOV, OP_BIC, OP_MVN: is_logic = 1'b1;
      default: begin
        is_cmp   = 1'b0;
        is_logic = 1'b0;
      end
    endcase
  end

  assign exec    = in_valid && pass && !stall;
  assign flag_wr = exec && (s_bit || is_cmp);
  assign wb_wr   = exec && !is_cmp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nzcv <= '0;
    end else if (flag_wr) begin
      // Logical ops leave V untouched.
      nzcv <= is_logic ? {alu_flags[3:1], nzcv[0]} : alu_flags;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else if (!stall) begin
      wb_valid <= wb_wr;
      if (wb_wr) begin
        wb_rd   <= rd;
        wb_data <= alu_out;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skip_count <= '0;
    end else if (in_valid && !pass && !stall && (skip_count != '1)) begin
      skip_count <= skip_count + 1'b1;
    end
  end

  assign carry_to_alu = nzcv[1];

endmodule

// File: tb/tb_cond_flag_stage.sv
// Directed-vector bench for cond_flag_stage with hand-computed expectations.
module tb_cond_flag_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        stall;
  logic [3:0]  cond;
  logic [3:0]  opcode;
  logic        s_bit;
  logic [3:0]  rd;
  logic [31:0] alu_out;
  logic [3:0]  alu_flags;
  logic [3:0]  nzcv;
  logic        carry_to_alu;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [7:0]  skip_count;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  cond_flag_stage #(.CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .stall        (stall),
    .cond         (cond),
    .opcode       (opcode),
    .s_bit        (s_bit),
    .rd           (rd),
    .alu_out      (alu_out),
    .alu_flags    (alu_flags),
    .nzcv         (nzcv),
    .carry_to_alu (carry_to_alu),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .skip_count   (skip_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [3:0] op, input logic s,
                       input logic [3:0] r, input logic [31:0] d, input logic [3:0] f);
    in_valid  = 1'b1;
    cond      = c;
    opcode    = op;
    s_bit     = s;
    rd        = r;
    alu_out   = d;
    alu_flags = f;
  endtask

  // Flag preset: ADDS under AL copies all four flags.
  task automatic preset(input logic [3:0] f);
    issue(4'hE, 4'h4, 1'b1, 4'h0, 32'h0, f);
    tick();
    check("preset_nzcv", {28'h0, nzcv}, {28'h0, f});
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; stall = 1'b0; cond = 4'hE; opcode = 4'h0;
    s_bit = 1'b0; rd = 4'h0; alu_out = '0; alu_flags = 4'h0;
    tick(); tick();
    check("rst_nzcv", {28'h0, nzcv}, 32'h0);
    check("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    check("rst_wb_rd", {28'h0, wb_rd}, 32'h0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_skip", {24'h0, skip_count}, 32'h0);
    reset = 1'b0;

    // 1: ADD without S writes back, flags untouched
    issue(4'hE, 4'h4, 1'b0, 4'd3, 32'd5, 4'b1111);
    tick();
    check("t1_wb_valid", {31'h0, wb_valid}, 32'h1);
    check("t1_wb_rd", {28'h0, wb_rd}, 32'd3);
    check("t1_wb_data", wb_data, 32'd5);
    check("t1_nzcv", {28'h0, nzcv}, 32'h0);

    // 2: CMP updates flags without S and never writes back
    issue(4'hE, 4'hA, 1'b0, 4'd7, 32'h9, 4'b0100);
    tick();
    check("t2_cmp_wb_valid", {31'h0, wb_valid}, 32'h0);
    check("t2_cmp_nzcv", {28'h0, nzcv}, 32'h4);
    check("t2_cmp_wb_rd_hold", {28'h0, wb_rd}, 32'd3);
    issue(4'h0, 4'h4, 1'b0, 4'd1, 32'h11, 4'b0000);
    tick();
    check("t2_eq_wb_valid", {31'h0, wb_valid}, 32'h1);
    check("t2_eq_wb_rd", {28'h0, wb_rd}, 32'd1);
    issue(4'h1, 4'h4, 1'b0, 4'd2, 32'h22, 4'b0000);
    tick();
    check("t2_ne_wb_valid", {31'h0, wb_valid}, 32'h0);
    check("t2_ne_skip", {24'h0, skip_count}, 32'd1);
    check("t2_ne_wb_data_hold", wb_data, 32'h11);

    // 3: logical compare preserves V; arithmetic S op replaces all
    preset(4'b0001);
    issue(4'hE, 4'h8, 1'b0, 4'd4, 32'h0, 4'b1010);
    tick();
    check("t3_tst_nzcv", {28'h0, nzcv}, 32'hB);
    check("t3_tst_wb_valid", {31'h0, wb_valid}, 32'h0);
    issue(4'hE, 4'h2, 1'b1, 4'd4, 32'h44, 4'b0010);
    tick();
    check("t3_subs_nzcv", {28'h0, nzcv}, 32'h2);
    check("t3_carry", {31'h0, carry_to_alu}, 32'h1);
    check("t3_subs_wb_data", wb_data, 32'h44);

    // 4: signed conditions
    preset(4'b1000);
    issue(4'hB, 4'h4, 1'b0, 4'd5, 32'h55, 4'b0000);
    tick();
    check("t4_lt_pass", {31'h0, wb_valid}, 32'h1);
    issue(4'hA, 4'h4, 1'b0, 4'd6, 32'h56, 4'b0000);
    tick();
    check("t4_ge_fail", {31'h0, wb_valid}, 32'h0);
    check("t4_skip", {24'h0, skip_count}, 32'd2);
    preset(4'b1001);
    issue(4'hA, 4'h4, 1'b0, 4'd5, 32'h57, 4'b0000);
    tick();
    check("t4_ge_pass", {31'h0, wb_valid}, 32'h1);
    issue(4'hC, 4'h4, 1'b0, 4'd6, 32'h58, 4'b0000);
    tick();
    check("t4_gt_pass", {31'h0, wb_valid}, 32'h1);
    check("t4_gt_wb_rd", {28'h0, wb_rd}, 32'd6);
    issue(4'hD, 4'h4, 1'b0, 4'd7, 32'h59, 4'b0000);
    tick();
    check("t4_le_fail", {31'h0, wb_valid}, 32'h0);
    check("t4_le_skip", {24'h0, skip_count}, 32'd3);

    // 5: stall freezes everything, then the held instruction commits once
    issue(4'hE, 4'h4, 1'b0, 4'd6, 32'h66, 4'b0000);
    tick();
    check("t5_pre_wb_valid", {31'h0, wb_valid}, 32'h1);
    issue(4'hE, 4'h4, 1'b1, 4'd8, 32'h88, 4'b1000);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_stall_nzcv", {28'h0, nzcv}, 32'h9);
      check("t5_stall_wb_valid", {31'h0, wb_valid}, 32'h1);
      check("t5_stall_wb_rd", {28'h0, wb_rd}, 32'd6);
      check("t5_stall_wb_data", wb_data, 32'h66);
      check("t5_stall_skip", {24'h0, skip_count}, 32'd3);
    end
    stall = 1'b0;
    tick();
    check("t5_rel_nzcv", {28'h0, nzcv}, 32'h8);
    check("t5_rel_wb_valid", {31'h0, wb_valid}, 32'h1);
    check("t5_rel_wb_rd", {28'h0, wb_rd}, 32'd8);
    check("t5_rel_wb_data", wb_data, 32'h88);
    issue(4'hF, 4'h4, 1'b1, 4'd9, 32'h99, 4'b0110);
    in_valid = 1'b0;
    tick();
    check("t5_idle_wb_valid", {31'h0, wb_valid}, 32'h0);
    check("t5_idle_nzcv", {28'h0, nzcv}, 32'h8);
    check("t5_idle_skip", {24'h0, skip_count}, 32'd3);

    // 6: NV saturation, then asynchronous reset mid-cycle
    issue(4'hF, 4'h4, 1'b1, 4'd9, 32'h99, 4'b0110);
    for (int i = 0; i < 300; i++) tick();
    check("t6_skip_sat", {24'h0, skip_count}, 32'd255);
    check("t6_nv_wb_valid", {31'h0, wb_valid}, 32'h0);
    check("t6_nv_nzcv", {28'h0, nzcv}, 32'h8);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_nzcv", {28'h0, nzcv}, 32'h0);
    check("t6_rst_skip", {24'h0, skip_count}, 32'h0);
    check("t6_rst_wb_rd", {28'h0, wb_rd}, 32'h0);
    check("t6_rst_wb_data", wb_data, 32'h0);
    check("t6_rst_carry", {31'h0, carry_to_alu}, 32'h0);
    tick();
    reset = 1'b0;
    issue(4'h1, 4'h4, 1'b0, 4'd2, 32'h12, 4'b0000);
    tick();
    check("t6_post_ne_pass", {31'h0, wb_valid}, 32'h1);
    issue(4'h0, 4'h4, 1'b0, 4'd3, 32'h13, 4'b0000);
    tick();
    check("t6_post_eq_fail", {31'h0, wb_valid}, 32'h0);
    check("t6_post_skip", {24'h0, skip_count}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
